// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window builder: pixel type,
// window geometry, window element indices and FSM state encoding.
package conv_pkg;

    localparam int PIXEL_W = 12;
    typedef logic [PIXEL_W-1:0] pixel_t;

    localparam int WIN_SIZE  = 3;
    localparam int WIN_ELEMS = 9;

    // Row-major window element indices, top-left to bottom-right
    localparam int W_TL = 0;
    localparam int W_TC = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_MC = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BC = 7;
    localparam int W_BR = 8;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/line_buffer.sv
// Single-row pixel store: combinational read and synchronous write at the
// same address, so a read in the write cycle returns the previous contents.
module line_buffer #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 12,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // Contents are left unreset; every entry is rewritten before it can
    // reach an emitted window.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_3x3.sv
// Turns a raster-order pixel stream into registered 3x3 neighbourhoods, one
// per interior pixel, with centre coordinates and a sticky end-of-frame flag.
module conv_window_3x3
    import conv_pkg::*;
#(
    parameter  int N          = PIXEL_W,
    parameter  int IMG_WIDTH  = 32,
    parameter  int IMG_HEIGHT = 32,
    localparam int CW         = $clog2(IMG_WIDTH),
    localparam int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           in_pixel,
    input  logic                   in_valid,
    output logic [WIN_ELEMS*N-1:0] window,
    output logic                   window_valid,
    output logic [RW-1:0]          win_row,
    output logic [CW-1:0]          win_col,
    output logic                   frame_done
);

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [N-1:0]           sr_q [WIN_ELEMS];
    logic [N-1:0]           sr_d [WIN_ELEMS];
    logic [WIN_ELEMS*N-1:0] window_q, window_d;
    logic                   window_valid_q, window_valid_d;
    logic [RW-1:0]          win_row_q, win_row_d;
    logic [CW-1:0]          win_col_q, win_col_d;
    logic                   frame_done_q, frame_done_d;

    logic         accept;
    logic         emit;
    logic         col_last;
    logic         row_last;
    logic [N-1:0] top_px;
    logic [N-1:0] mid_px;

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(N)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (in_pixel),
        .rd_data (mid_px)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(N)) u_lb2 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (mid_px),
        .rd_data (top_px)
    );

    // The c>=2 qualifier is what hides columns left over from the previous row
    always_comb begin
        accept   = in_valid && (state_q != ST_DONE);
        col_last = (col_q == CW'(IMG_WIDTH - 1));
        row_last = (row_q == RW'(IMG_HEIGHT - 1));
        emit     = accept && (state_q == ST_STREAM) && (col_q >= CW'(WIN_SIZE - 1));

        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        sr_d           = sr_q;
        window_d       = window_q;
        window_valid_d = emit;
        win_row_d      = win_row_q;
        win_col_d      = win_col_q;
        frame_done_d   = frame_done_q;

        if (accept) begin
            sr_d[W_TL] = sr_q[W_TC];
            sr_d[W_TC] = sr_q[W_TR];
            sr_d[W_TR] = top_px;
            sr_d[W_ML] = sr_q[W_MC];
            sr_d[W_MC] = sr_q[W_MR];
            sr_d[W_MR] = mid_px;
            sr_d[W_BL] = sr_q[W_BC];
            sr_d[W_BC] = sr_q[W_BR];
            sr_d[W_BR] = in_pixel;

            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                    if (row_q == RW'(1)) begin
                        state_d = ST_STREAM;
                    end
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (emit) begin
            for (int i = 0; i < WIN_ELEMS; i++) begin
                window_d[i*N +: N] = sr_d[i];
            end
            win_row_d = row_q - RW'(1);
            win_col_d = col_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_FILL;
            col_q          <= '0;
            row_q          <= '0;
            window_q       <= '0;
            window_valid_q <= 1'b0;
            win_row_q      <= '0;
            win_col_q      <= '0;
            frame_done_q   <= 1'b0;
            for (int i = 0; i < WIN_ELEMS; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
            win_row_q      <= win_row_d;
            win_col_q      <= win_col_d;
            frame_done_q   <= frame_done_d;
            for (int i = 0; i < WIN_ELEMS; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

    assign window       = window_q;
    assign window_valid = window_valid_q;
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Scoreboard bench for conv_window_3x3: three frame geometries (4x4, 5x3, 3x3)
// driven with directed pixels; expected windows are hand-written constants.
module tb_conv_window_3x3;
    import conv_pkg::*;

    localparam int N = 12;

    typedef struct packed {
        logic [9*N-1:0] win;
        logic [2:0]     row;
        logic [2:0]     col;
        logic           fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    pixel_t pix_a, pix_b, pix_c;
    logic   val_a, val_b, val_c;

    logic [9*N-1:0] win_a, win_b, win_c;
    logic           wv_a, wv_b, wv_c;
    logic [1:0]     row_a, row_b, row_c;
    logic [1:0]     col_a, col_c;
    logic [2:0]     col_b;
    logic           fd_a, fd_b, fd_c;

    int total = 0;
    int bad   = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ea, eb, ec;

    logic inv_prev_a = 1'b0;

    conv_window_3x3 #(.N(N), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk (clk), .reset (reset), .in_pixel (pix_a), .in_valid (val_a),
        .window (win_a), .window_valid (wv_a), .win_row (row_a), .win_col (col_a),
        .frame_done (fd_a)
    );

    conv_window_3x3 #(.N(N), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
        .clk (clk), .reset (reset), .in_pixel (pix_b), .in_valid (val_b),
        .window (win_b), .window_valid (wv_b), .win_row (row_b), .win_col (col_b),
        .frame_done (fd_b)
    );

    conv_window_3x3 #(.N(N), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut_c (
        .clk (clk), .reset (reset), .in_pixel (pix_c), .in_valid (val_c),
        .window (win_c), .window_valid (wv_c), .win_row (row_c), .win_col (col_c),
        .frame_done (fd_c)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got window_valid=1 expected no window", name);
    endtask

    function automatic logic [9*N-1:0] pack9(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5,
                                             input int a6, input int a7, input int a8);
        logic [9*N-1:0] p;
        p[0*N +: N] = a0[N-1:0];
        p[1*N +: N] = a1[N-1:0];
        p[2*N +: N] = a2[N-1:0];
        p[3*N +: N] = a3[N-1:0];
        p[4*N +: N] = a4[N-1:0];
        p[5*N +: N] = a5[N-1:0];
        p[6*N +: N] = a6[N-1:0];
        p[7*N +: N] = a7[N-1:0];
        p[8*N +: N] = a8[N-1:0];
        return p;
    endfunction

    function automatic exp_t mk(input logic [9*N-1:0] w, input int r, input int c, input bit fd);
        exp_t e;
        e.win = w;
        e.row = r[2:0];
        e.col = c[2:0];
        e.fd  = fd;
        return e;
    endfunction

    // Window valid must only follow an accepting edge on instance A
    always @(posedge clk) inv_prev_a <= val_a;

    always @(negedge clk) begin
        if (wv_a) begin
            check("a_no_window_after_gap", 128'(inv_prev_a), 128'(1));
            if (qa.size() == 0) begin
                unexpected("a_unexpected_window");
            end else begin
                ea = qa.pop_front();
                check("a_window", 128'(win_a), 128'(ea.win));
                check("a_row", 128'(row_a), 128'(ea.row));
                check("a_col", 128'(col_a), 128'(ea.col));
                check("a_frame_done", 128'(fd_a), 128'(ea.fd));
            end
        end
    end

    always @(negedge clk) begin
        if (wv_b) begin
            if (qb.size() == 0) begin
                unexpected("b_unexpected_window");
            end else begin
                eb = qb.pop_front();
                check("b_window", 128'(win_b), 128'(eb.win));
                check("b_row", 128'(row_b), 128'(eb.row));
                check("b_col", 128'(col_b), 128'(eb.col));
                check("b_frame_done", 128'(fd_b), 128'(eb.fd));
            end
        end
    end

    always @(negedge clk) begin
        if (wv_c) begin
            if (qc.size() == 0) begin
                unexpected("c_unexpected_window");
            end else begin
                ec = qc.pop_front();
                check("c_window", 128'(win_c), 128'(ec.win));
                check("c_row", 128'(row_c), 128'(ec.row));
                check("c_col", 128'(col_c), 128'(ec.col));
                check("c_frame_done", 128'(fd_c), 128'(ec.fd));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Optionally holds in_valid high during reset to prove that pixel is dropped
    task automatic do_reset(input bit valid_during);
        reset = 1'b1;
        val_a = valid_during;
        pix_a = 12'hABC;
        idle(2);
        reset = 1'b0;
        val_a = 1'b0;
        idle(1);
    endtask

    // Full 4x4 frame on instance A, pixels 0..15, optionally one idle cycle after each
    task automatic apply_stimulus_a(input bit gapped);
        for (int i = 0; i < 16; i++) begin
            case (i)
                10: qa.push_back(mk(pack9(0, 1, 2, 4, 5, 6, 8, 9, 10), 1, 1, 1'b0));
                11: qa.push_back(mk(pack9(1, 2, 3, 5, 6, 7, 9, 10, 11), 1, 2, 1'b0));
                14: qa.push_back(mk(pack9(4, 5, 6, 8, 9, 10, 12, 13, 14), 2, 1, 1'b0));
                15: qa.push_back(mk(pack9(5, 6, 7, 9, 10, 11, 13, 14, 15), 2, 2, 1'b1));
                default: ;
            endcase
            pix_a = 12'(i);
            val_a = 1'b1;
            @(negedge clk);
            if (gapped) begin
                val_a = 1'b0;
                @(negedge clk);
            end
        end
        val_a = 1'b0;
    endtask

    task automatic check_output_a(input string tag);
        idle(3);
        check({tag, "_all_windows_seen"}, 128'(qa.size()), 128'(0));
        check({tag, "_frame_done"}, 128'(fd_a), 128'(1));
    endtask

    initial begin
        reset = 1'b1;
        pix_a = '0; pix_b = '0; pix_c = '0;
        val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
        idle(3);

        check("reset_window", 128'(win_a), 128'(0));
        check("reset_window_valid", 128'(wv_a), 128'(0));
        check("reset_win_row", 128'(row_a), 128'(0));
        check("reset_win_col", 128'(col_a), 128'(0));
        check("reset_frame_done", 128'(fd_a), 128'(0));
        reset = 1'b0;
        idle(1);

        $display("[TB] basic 4x4");
        apply_stimulus_a(1'b0);
        check_output_a("basic");

        $display("[TB] post-done pixels");
        for (int i = 0; i < 5; i++) begin
            pix_a = 12'hFFF;
            val_a = 1'b1;
            @(negedge clk);
        end
        val_a = 1'b0;
        idle(2);
        check("post_done_frame_done", 128'(fd_a), 128'(1));
        check("post_done_window_held", 128'(win_a),
              128'(pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)));
        check("post_done_no_valid", 128'(wv_a), 128'(0));

        $display("[TB] reset mid-frame");
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            pix_a = 12'(i);
            val_a = 1'b1;
            @(negedge clk);
        end
        do_reset(1'b1);
        check("abort_frame_done_cleared", 128'(fd_a), 128'(0));
        check("abort_window_cleared", 128'(win_a), 128'(0));
        apply_stimulus_a(1'b0);
        check_output_a("replay");

        $display("[TB] gapped 4x4");
        do_reset(1'b0);
        apply_stimulus_a(1'b1);
        check_output_a("gapped");

        $display("[TB] non-square 5x3");
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) begin
            case (i)
                12: qb.push_back(mk(pack9(0, 1, 2, 5, 6, 7, 10, 11, 12), 1, 1, 1'b0));
                13: qb.push_back(mk(pack9(1, 2, 3, 6, 7, 8, 11, 12, 13), 1, 2, 1'b0));
                14: qb.push_back(mk(pack9(2, 3, 4, 7, 8, 9, 12, 13, 14), 1, 3, 1'b1));
                default: ;
            endcase
            pix_b = 12'(i);
            val_b = 1'b1;
            @(negedge clk);
        end
        val_b = 1'b0;
        idle(3);
        check("b_all_windows_seen", 128'(qb.size()), 128'(0));
        check("b_frame_done", 128'(fd_b), 128'(1));

        $display("[TB] full-scale 3x3");
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                qc.push_back(mk(pack9('hFFF, 0, 'hFFF, 0, 'hFFF, 0, 'hFFF, 0, 'hFFF), 1, 1, 1'b1));
            end
            pix_c = (i % 2 == 0) ? 12'hFFF : 12'h000;
            val_c = 1'b1;
            @(negedge clk);
        end
        val_c = 1'b0;
        idle(3);
        check("c_all_windows_seen", 128'(qc.size()), 128'(0));
        check("c_frame_done", 128'(fd_c), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
